// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: bubble instruction, RV32I major opcodes,
// the MW stage record and the MW slot state encoding.
package pipe_pkg;

    localparam logic [31:0] NOP_INSTR     = 32'h0000_0013;  // addi x0, x0, 0

    localparam logic [6:0]  OPC_R         = 7'd51;
    localparam logic [6:0]  OPC_I_ALU     = 7'd19;
    localparam logic [6:0]  OPC_LOAD      = 7'd3;
    localparam logic [6:0]  OPC_STORE     = 7'd35;
    localparam logic [6:0]  OPC_BRANCH    = 7'd99;
    localparam logic [6:0]  OPC_JALR      = 7'd103;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] alu_res;
        logic [31:0] wdata;
        logic        valid;
    } mw_stage_t;

    typedef enum logic [0:0] {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    // Empty slot contents: NOP so downstream hazard logic sees rd = x0.
    function automatic mw_stage_t mw_bubble();
        mw_stage_t b;
        b.pc      = 32'h0000_0000;
        b.instr   = NOP_INSTR;
        b.alu_res = 32'h0000_0000;
        b.wdata   = 32'h0000_0000;
        b.valid   = 1'b0;
        return b;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high reset and increment
// enable. Sticks at all-ones once reached.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: add one unless disabled or already saturated.
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= {W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/de_mw_pipe_reg.sv
// Decode/execute -> memory/writeback pipeline register.
// Priority per edge: rst > stall > flush (live or pending) > load.
// A flush seen during a stall is remembered in flush_pend and applied as a
// single bubble on the first non-stalled cycle.
// Optional build macro DE_MW_PERF_CNT_EN adds saturating stall/flush/retire
// counters; without it the counter ports read 32'h0 and no counter flops exist.
module de_mw_pipe_reg
    import pipe_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] pc_DE,
    input  logic [31:0] instr_DE,
    input  logic [31:0] alu_res_DE,
    input  logic [31:0] wdata_DE,
    output logic [31:0] pc_MW,
    output logic [31:0] instr_MW,
    output logic [31:0] alu_res_MW,
    output logic [31:0] wdata_MW,
    output logic        valid_MW,
    output logic        flush_pend,
    output logic [31:0] cnt_stall,
    output logic [31:0] cnt_flush,
    output logic [31:0] cnt_retire
);

    mw_stage_t   mw_q;
    mw_stage_t   mw_d;
    slot_state_e state_q;
    slot_state_e state_d;
    logic        flush_pend_q;
    logic        flush_pend_d;

    // Slot next-state and next contents: hold, bubble or load.
    always_comb begin
        mw_d         = mw_q;
        state_d      = state_q;
        flush_pend_d = flush_pend_q;
        if (stall) begin
            // Frozen; only remember a flush for later.
            flush_pend_d = flush_pend_q | flush;
        end else if (flush || flush_pend_q) begin
            // Live and pending flush merge into one bubble.
            mw_d         = mw_bubble();
            state_d      = SLOT_EMPTY;
            flush_pend_d = 1'b0;
        end else begin
            mw_d.pc      = pc_DE;
            mw_d.instr   = instr_DE;
            mw_d.alu_res = alu_res_DE;
            mw_d.wdata   = wdata_DE;
            mw_d.valid   = 1'b1;
            state_d      = SLOT_FULL;
            flush_pend_d = 1'b0;
        end
    end

    // Slot registers with synchronous reset to an empty bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            mw_q         <= mw_bubble();
            state_q      <= SLOT_EMPTY;
            flush_pend_q <= 1'b0;
        end else begin
            mw_q         <= mw_d;
            state_q      <= state_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    assign pc_MW      = mw_q.pc;
    assign instr_MW   = mw_q.instr;
    assign alu_res_MW = mw_q.alu_res;
    assign wdata_MW   = mw_q.wdata;
    assign valid_MW   = mw_q.valid;
    assign flush_pend = flush_pend_q;

`ifdef DE_MW_PERF_CNT_EN
    logic load_s;
    logic flush_apply_s;

    assign load_s        = ~stall & ~(flush | flush_pend_q);
    assign flush_apply_s = ~stall &  (flush | flush_pend_q);

    sat_counter #(.W(32)) u_cnt_stall (
        .clk   (clk),
        .rst   (rst),
        .inc_i (stall),
        .cnt_o (cnt_stall)
    );

    sat_counter #(.W(32)) u_cnt_flush (
        .clk   (clk),
        .rst   (rst),
        .inc_i (flush_apply_s),
        .cnt_o (cnt_flush)
    );

    sat_counter #(.W(32)) u_cnt_retire (
        .clk   (clk),
        .rst   (rst),
        .inc_i (load_s),
        .cnt_o (cnt_retire)
    );
`else
    assign cnt_stall  = 32'h0000_0000;
    assign cnt_flush  = 32'h0000_0000;
    assign cnt_retire = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_de_mw_pipe_reg.sv
// Directed bench for de_mw_pipe_reg. Counter expectations are the hand
// counts when DE_MW_PERF_CNT_EN is defined, otherwise zero.
module tb_de_mw_pipe_reg;

    logic        clk = 1'b0;
    logic        rst, stall, flush;
    logic [31:0] pc_DE, instr_DE, alu_res_DE, wdata_DE;
    logic [31:0] pc_MW, instr_MW, alu_res_MW, wdata_MW;
    logic        valid_MW, flush_pend;
    logic [31:0] cnt_stall, cnt_flush, cnt_retire;

    int n_checks = 0;
    int n_errors = 0;

    de_mw_pipe_reg dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .flush      (flush),
        .pc_DE      (pc_DE),
        .instr_DE   (instr_DE),
        .alu_res_DE (alu_res_DE),
        .wdata_DE   (wdata_DE),
        .pc_MW      (pc_MW),
        .instr_MW   (instr_MW),
        .alu_res_MW (alu_res_MW),
        .wdata_MW   (wdata_MW),
        .valid_MW   (valid_MW),
        .flush_pend (flush_pend),
        .cnt_stall  (cnt_stall),
        .cnt_flush  (cnt_flush),
        .cnt_retire (cnt_retire)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [31:0] cexp(input logic [31:0] v);
`ifdef DE_MW_PERF_CNT_EN
        return v;
`else
        return 32'h0000_0000 & v;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_de(input logic [31:0] pc, input logic [31:0] ins,
                          input logic [31:0] alu, input logic [31:0] wd);
        pc_DE = pc; instr_DE = ins; alu_res_DE = alu; wdata_DE = wd;
    endtask

    task automatic check_bubble(input string tag);
        check_val({tag, "_instr"}, instr_MW, 32'h0000_0013);
        check_val({tag, "_pc"}, pc_MW, 32'h0);
        check_val({tag, "_alu"}, alu_res_MW, 32'h0);
        check_val({tag, "_wdata"}, wdata_MW, 32'h0);
        check_val({tag, "_valid"}, {31'h0, valid_MW}, 32'h0);
    endtask

    task automatic check_cnts(input string tag, input logic [31:0] s,
                              input logic [31:0] f, input logic [31:0] r);
        check_val({tag, "_cnt_stall"}, cnt_stall, cexp(s));
        check_val({tag, "_cnt_flush"}, cnt_flush, cexp(f));
        check_val({tag, "_cnt_retire"}, cnt_retire, cexp(r));
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        set_de(32'hDEAD_0000, 32'h0000_00B3, 32'h1111_1111, 32'h2222_2222);
        tick(); tick();
        check_bubble("reset");
        check_val("reset_pend", {31'h0, flush_pend}, 32'h0);
        check_cnts("reset", 32'd0, 32'd0, 32'd0);

        // Load right after reset release
        rst = 1'b0;
        set_de(32'h10, 32'h0020_81B3, 32'h5, 32'h7);
        tick();
        check_val("load_instr", instr_MW, 32'h0020_81B3);
        check_val("load_pc", pc_MW, 32'h10);
        check_val("load_alu", alu_res_MW, 32'h5);
        check_val("load_wdata", wdata_MW, 32'h7);
        check_val("load_valid", {31'h0, valid_MW}, 32'h1);
        check_cnts("load", 32'd0, 32'd0, 32'd1);

        set_de(32'h14, 32'h00A0_0093, 32'hA, 32'hB);
        tick();
        check_val("load2_pc", pc_MW, 32'h14);
        check_val("load2_instr", instr_MW, 32'h00A0_0093);
        check_cnts("load2", 32'd0, 32'd0, 32'd2);

        // Flush of a full slot
        flush = 1'b1;
        set_de(32'h18, 32'h4020_8233, 32'hC, 32'hD);
        tick();
        flush = 1'b0;
        check_bubble("flush");
        check_cnts("flush", 32'd0, 32'd1, 32'd2);

        tick();
        check_val("reload_pc", pc_MW, 32'h18);
        check_val("reload_valid", {31'h0, valid_MW}, 32'h1);
        check_cnts("reload", 32'd0, 32'd1, 32'd3);

        // Flush during a 3-cycle stall
        stall = 1'b1; flush = 1'b1;
        set_de(32'h1C, 32'h0000_0003, 32'hE, 32'hF);
        tick();
        flush = 1'b0;
        check_val("stf1_pc", pc_MW, 32'h18);
        check_val("stf1_valid", {31'h0, valid_MW}, 32'h1);
        check_val("stf1_pend", {31'h0, flush_pend}, 32'h1);
        tick();
        check_val("stf2_pc", pc_MW, 32'h18);
        check_val("stf2_pend", {31'h0, flush_pend}, 32'h1);
        tick();
        check_val("stf3_instr", instr_MW, 32'h4020_8233);
        check_val("stf3_pend", {31'h0, flush_pend}, 32'h1);
        check_cnts("stf3", 32'd3, 32'd1, 32'd3);
        stall = 1'b0;
        tick();
        check_bubble("stf_apply");
        check_val("stf_apply_pend", {31'h0, flush_pend}, 32'h0);
        check_cnts("stf_apply", 32'd3, 32'd2, 32'd3);

        // Live flush coinciding with pending flush: one bubble only
        set_de(32'h20, 32'h0000_0023, 32'h1, 32'h2);
        tick();
        check_val("ld20_pc", pc_MW, 32'h20);
        stall = 1'b1; flush = 1'b1;
        tick();
        check_val("dbl_pend", {31'h0, flush_pend}, 32'h1);
        stall = 1'b0;
        tick();
        flush = 1'b0;
        check_bubble("dbl");
        check_val("dbl_pend_clr", {31'h0, flush_pend}, 32'h0);
        check_cnts("dbl", 32'd4, 32'd3, 32'd4);
        tick();
        check_val("after_dbl_pc", pc_MW, 32'h20);
        check_val("after_dbl_valid", {31'h0, valid_MW}, 32'h1);
        check_cnts("after_dbl", 32'd4, 32'd3, 32'd5);

        // Plain stall holds contents, no pending flush
        stall = 1'b1;
        set_de(32'h24, 32'h0000_0063, 32'h3, 32'h4);
        tick();
        check_val("hold_pc", pc_MW, 32'h20);
        check_val("hold_alu", alu_res_MW, 32'h1);
        check_val("hold_pend", {31'h0, flush_pend}, 32'h0);

        // Reset mid-stall with a pending flush
        flush = 1'b1;
        tick();
        check_val("pre_rst_pend", {31'h0, flush_pend}, 32'h1);
        check_cnts("pre_rst", 32'd6, 32'd3, 32'd5);
        rst = 1'b1;
        tick();
        check_bubble("rst_mid");
        check_val("rst_mid_pend", {31'h0, flush_pend}, 32'h0);
        check_cnts("rst_mid", 32'd0, 32'd0, 32'd0);

        // First edge after reset loads
        rst = 1'b0; stall = 1'b0; flush = 1'b0;
        set_de(32'h40, 32'h0000_0067, 32'h9, 32'h8);
        tick();
        check_val("post_rst_pc", pc_MW, 32'h40);
        check_val("post_rst_instr", instr_MW, 32'h0000_0067);
        check_val("post_rst_valid", {31'h0, valid_MW}, 32'h1);
        check_cnts("post_rst", 32'd0, 32'd0, 32'd1);

        // Stall counter saturation
`ifdef DE_MW_PERF_CNT_EN
        force dut.u_cnt_stall.cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.u_cnt_stall.cnt_q;
        stall = 1'b1;
        tick();
        check_val("sat1", cnt_stall, 32'hFFFF_FFFF);
        tick();
        check_val("sat2", cnt_stall, 32'hFFFF_FFFF);
        tick();
        check_val("sat3", cnt_stall, 32'hFFFF_FFFF);
`else
        stall = 1'b1;
        tick(); tick(); tick();
        check_val("sat_off", cnt_stall, 32'h0);
`endif
        check_val("sat_hold_pc", pc_MW, 32'h40);
        stall = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/de_mw_pipe_reg.md
DE_MW_PIPE_REG -- requirements
Module: de_mw_pipe_reg

Interface
REQ-001 SHALL use one clock and a synchronous, active-high reset: clk rising-edge, rst sampled only at the clk edge.
REQ-002 SHALL have ports: clk  in  1  system clock.
REQ-003 SHALL have ports: rst  in  1  synchronous active-high reset.
REQ-004 SHALL have ports: stall  in  1  hold MW contents (data memory/UART busy).
REQ-005 SHALL have ports: flush  in  1  kill the instruction currently in DE (branch/jump taken).
REQ-006 SHALL have ports: pc_DE, instr_DE, alu_res_DE, wdata_DE  in  32 each  decode/execute stage outputs.
REQ-007 SHALL have ports: pc_MW, instr_MW, alu_res_MW, wdata_MW  out  32 each  registered copies feeding memory-writeback and forwarding.
REQ-008 SHALL have ports: valid_MW  out  1  MW slot holds a real instruction.
REQ-009 SHALL have ports: flush_pend  out  1  flush captured during stall, not yet applied.
REQ-010 SHALL have ports: cnt_stall, cnt_flush, cnt_retire  out  32 each  performance counters.

Function
REQ-011 SHALL evaluate per clk edge with priority rst > stall > flush-or-flush_pend > load.
REQ-012 SHALL, on load (no stall, no flush, no flush_pend), capture all four DE inputs and set valid_MW=1; latency one cycle.
REQ-013 SHALL, on applied flush, write bubble: instr_MW=NOP (32'h00000013), pc/alu_res/wdata_MW=0, valid_MW=0.
REQ-014 SHALL, while stall=1, hold all MW outputs unchanged regardless of flush.
REQ-015 SHALL set flush_pend=1 when flush=1 and stall=1; hold it through further stall cycles.
REQ-016 SHALL apply pending flush (bubble) on the first cycle stall=0, clearing flush_pend on that edge, even if flush=0.
REQ-017 SHALL treat flush=1 with flush_pend=1 on a non-stall cycle as a single flush (one bubble, cnt_flush +1).
REQ-018 SHALL present instr_MW as NOP whenever valid_MW=0 so downstream hazard logic sees rd=x0.
REQ-019 SHALL form the two-state slot machine EMPTY(valid_MW=0)/FULL(valid_MW=1): load -> FULL, flush -> EMPTY, stall -> stay.
REQ-020 SHALL increment cnt_stall each cycle stall=1, cnt_flush each applied flush, cnt_retire each load, all saturating at 32'hFFFFFFFF.

Reset
REQ-021 SHALL on rst=1 set instr_MW=NOP, pc/alu_res/wdata_MW=0, valid_MW=0, flush_pend=0, all counters=0.
REQ-022 SHALL let rst override stall and flush in the same cycle, discarding any pending flush.
REQ-023 SHALL load normally on the first edge after rst deasserts if stall=0 and flush=0.

Configuration
REQ-024 SHALL gate counters with macro DE_MW_PERF_CNT_EN.
REQ-025 SHALL, with DE_MW_PERF_CNT_EN defined, implement REQ-020 counters.
REQ-026 SHALL, without DE_MW_PERF_CNT_EN, keep counter ports present but tie them to 32'h0 with no counter flops; all other behaviour identical.

Structure
REQ-027 SHALL take NOP_INSTR, the opcode constants (R=51, I-ALU=19, LOAD=3, STORE=35, BRANCH=99, JALR=103) and the packed struct mw_stage_t {pc, instr, alu_res, wdata, valid} from shared package pipe_pkg.
REQ-028 SHALL instantiate sub-module sat_counter (32-bit, synchronous reset, inc enable, saturating) three times, only under DE_MW_PERF_CNT_EN.

Verification
REQ-029 SHALL cover load: rst released, instr_DE=32'h002081B3, pc_DE=32'h10, no stall/flush -> next cycle instr_MW=32'h002081B3, pc_MW=32'h10, valid_MW=1, cnt_retire=1.
REQ-030 SHALL cover flush: FULL slot, flush=1 one cycle -> instr_MW=32'h00000013, valid_MW=0, cnt_flush=1.
REQ-031 SHALL cover flush during stall: stall=1 for 3 cycles with flush=1 in cycle 1 -> outputs frozen, flush_pend=1 for cycles 2-3; stall drops -> bubble, flush_pend=0, cnt_flush=1, cnt_stall=3.
REQ-032 SHALL cover reset mid-stall with flush_pend=1: rst=1 -> all outputs reset values, flush_pend=0, counters 0.
REQ-033 SHALL cover saturation: force cnt_stall to 32'hFFFFFFFE, stall=1 for 3 cycles -> cnt_stall=32'hFFFFFFFF and holds.
REQ-034 SHALL cover build without DE_MW_PERF_CNT_EN: scenarios REQ-029..031 pass with all counters reading 0.
